// File: rtl/mdec_cmd_sequencer_pkg.sv
// Shared MDEC constants for the command sequencer slice.
// Holds the command opcodes, the sequencer state encoding, the depth/sign setup
// types driven to the core, and a helper giving the word count of a table load.
package mdec_cmd_sequencer_pkg;

    localparam logic [2:0] OP_DECODE = 3'd1;
    localparam logic [2:0] OP_QUANT  = 3'd2;
    localparam logic [2:0] OP_COS    = 3'd3;

    typedef logic [1:0] MDEC_TPIX;
    typedef logic       MDEC_SIGN;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecLo,
        StDecHi,
        StTbl,
        StDrain
    } seqState_t;

    // Quant loads carry one table (16 words) unless bit 0 asks for luma+chroma.
    function automatic logic [5:0] tblWords(input logic [2:0] op, input logic lenLsb);
        return (op == OP_QUANT && !lenLsb) ? 6'd16 : 6'd32;
    endfunction

endpackage

// File: rtl/mdec_cmd_sequencer_if.sv
// Command FIFO and RLE stream bundle between the sequencer and its neighbours.
//   i_cmdValid / i_cmdWord / o_cmdPop   : host command FIFO head and pop strobe
//   i_allowLoad / o_dataWrite / o_dataIn : core RLE halfword port
// master = sequencer side, slave = FIFO/core side.
interface mdec_cmd_sequencer_if;

    logic        i_cmdValid;
    logic [31:0] i_cmdWord;
    logic        o_cmdPop;
    logic        i_allowLoad;
    logic        o_dataWrite;
    logic [15:0] o_dataIn;

    modport master (
        input  i_cmdValid, i_cmdWord, i_allowLoad,
        output o_cmdPop, o_dataWrite, o_dataIn
    );

    modport slave (
        output i_cmdValid, i_cmdWord, i_allowLoad,
        input  o_cmdPop, o_dataWrite, o_dataIn
    );

endinterface

// File: rtl/mdec_tbl_loader.sv
// Table-load address counter and field repacking for quant/cos commands.
// Ports:
//   clk, i_nrst      clock, asynchronous active-low reset
//   i_clear          restart the address counter at 0
//   i_wrEn           a table word is popped and written this cycle
//   i_isCos          1 = cos table, 0 = quant table
//   i_word           table word from the command FIFO head
//   o_quant*         quant write strobe, packed 4x7-bit value, address, table select
//   o_cos*           cos write strobe, index, packed 2x13-bit value
// All outputs are 0 when no write happens.
module mdec_tbl_loader
    import mdec_cmd_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        i_nrst,
    input  logic        i_clear,
    input  logic        i_wrEn,
    input  logic        i_isCos,
    input  logic [31:0] i_word,
    output logic        o_quantWrt,
    output logic [27:0] o_quantValue,
    output logic [3:0]  o_quantAdr,
    output logic        o_quantTblSelect,
    output logic        o_cosWrite,
    output logic [4:0]  o_cosIndex,
    output logic [25:0] o_cosVal
);

    logic [4:0] kQ;
    logic       unusedBits;

    // Bits 31 and 15 carry no table data in either format.
    assign unusedBits = ^{i_word[31], i_word[15]};

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            kQ <= '0;
        end else if (i_clear) begin
            kQ <= '0;
        end else if (i_wrEn) begin
            kQ <= kQ + 5'd1;
        end
    end

    always_comb begin
        o_quantWrt       = 1'b0;
        o_quantValue     = '0;
        o_quantAdr       = '0;
        o_quantTblSelect = 1'b0;
        o_cosWrite       = 1'b0;
        o_cosIndex       = '0;
        o_cosVal         = '0;
        if (i_wrEn) begin
            if (i_isCos) begin
                o_cosWrite = 1'b1;
                o_cosIndex = kQ;
                o_cosVal   = {i_word[28:16], i_word[12:0]};
            end else begin
                o_quantWrt       = 1'b1;
                o_quantValue     = {i_word[30:24], i_word[22:16], i_word[14:8], i_word[6:0]};
                o_quantAdr       = kQ[3:0];
                o_quantTblSelect = kQ[4];
            end
        end
    end

endmodule

// File: rtl/mdec_cmd_sequencer.sv
// MDEC command front-end: pops command/parameter words from the host FIFO,
// feeds RLE halfwords to the core and loads the quant/cos tables.
// Ports:
//   clk, i_nrst          clock, asynchronous active-low reset
//   i_abort              (only with MDEC_SEQ_ABORT_EN) abandon the current command
//   bus                  FIFO pop handshake and RLE halfword stream (master side)
//   i_stillIDCT          core IDCT busy, holds DRAIN
//   o_bitSetupDepth/o_bitSigned   depth/sign latched at each decode command
//   o_quant* / o_cos*    table write ports
//   o_busy, o_curCmd, o_remain    status
// Optional build macro: MDEC_SEQ_ABORT_EN adds the i_abort input.
module mdec_cmd_sequencer
    import mdec_cmd_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             i_nrst,
`ifdef MDEC_SEQ_ABORT_EN
    input  logic             i_abort,
`endif
    mdec_cmd_sequencer_if.master bus,
    input  logic             i_stillIDCT,
    output MDEC_TPIX         o_bitSetupDepth,
    output MDEC_SIGN         o_bitSigned,
    output logic             o_quantWrt,
    output logic [27:0]      o_quantValue,
    output logic [3:0]       o_quantAdr,
    output logic             o_quantTblSelect,
    output logic             o_cosWrite,
    output logic [4:0]       o_cosIndex,
    output logic [25:0]      o_cosVal,
    output logic             o_busy,
    output logic [2:0]       o_curCmd,
    output logic [CNT_W-1:0] o_remain
);

    seqState_t        stateQ, stateD;
    logic [CNT_W-1:0] remainQ, remainD;
    logic [2:0]       curCmdQ, curCmdD;
    MDEC_TPIX         depthQ, depthD;
    MDEC_SIGN         signQ, signD;
    logic [31:0]      wordQ, wordD;
    logic             abort;
    logic             tblWr;
    logic [2:0]       op;
    logic             inDecode;

`ifdef MDEC_SEQ_ABORT_EN
    assign abort = i_abort;
`else
    assign abort = 1'b0;
`endif

    assign op       = bus.i_cmdWord[31:29];
    assign inDecode = (curCmdQ == OP_DECODE) && (stateQ inside {StFetch, StDecLo, StDecHi});

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            stateQ  <= StIdle;
            remainQ <= '0;
            curCmdQ <= '0;
            depthQ  <= '0;
            signQ   <= 1'b0;
            wordQ   <= '0;
        end else begin
            stateQ  <= stateD;
            remainQ <= remainD;
            curCmdQ <= curCmdD;
            depthQ  <= depthD;
            signQ   <= signD;
            wordQ   <= wordD;
        end
    end

    always_comb begin
        stateD          = stateQ;
        remainD         = remainQ;
        curCmdD         = curCmdQ;
        depthD          = depthQ;
        signD           = signQ;
        wordD           = wordQ;
        bus.o_cmdPop    = 1'b0;
        bus.o_dataWrite = 1'b0;
        bus.o_dataIn    = '0;
        tblWr           = 1'b0;

        // DRAIN is already the safe path, so abort leaves it to finish normally.
        if (abort && stateQ != StDrain) begin
            remainD = '0;
            if (inDecode) begin
                stateD = StDrain;
            end else begin
                stateD  = StIdle;
                curCmdD = '0;
            end
        end else begin
            case (stateQ)
                StIdle: begin
                    if (bus.i_cmdValid) begin
                        bus.o_cmdPop = 1'b1;
                        case (op)
                            OP_DECODE: begin
                                curCmdD = op;
                                depthD  = bus.i_cmdWord[28:27];
                                signD   = bus.i_cmdWord[26];
                                remainD = bus.i_cmdWord[CNT_W-1:0];
                                stateD  = (bus.i_cmdWord[CNT_W-1:0] == '0) ? StDrain : StFetch;
                            end
                            OP_QUANT, OP_COS: begin
                                curCmdD = op;
                                remainD = CNT_W'(tblWords(op, bus.i_cmdWord[0]));
                                stateD  = StTbl;
                            end
                            default: ; // unknown opcode: word is consumed as a no-op
                        endcase
                    end
                end
                StFetch: begin
                    if (bus.i_cmdValid) begin
                        bus.o_cmdPop = 1'b1;
                        wordD        = bus.i_cmdWord;
                        remainD      = remainQ - CNT_W'(1);
                        stateD       = StDecLo;
                    end
                end
                StDecLo: begin
                    bus.o_dataIn    = wordQ[15:0];
                    bus.o_dataWrite = bus.i_allowLoad;
                    if (bus.i_allowLoad) stateD = StDecHi;
                end
                StDecHi: begin
                    bus.o_dataIn    = wordQ[31:16];
                    bus.o_dataWrite = bus.i_allowLoad;
                    if (bus.i_allowLoad) stateD = (remainQ != '0) ? StFetch : StDrain;
                end
                StTbl: begin
                    if (bus.i_cmdValid) begin
                        bus.o_cmdPop = 1'b1;
                        tblWr        = 1'b1;
                        remainD      = remainQ - CNT_W'(1);
                        if (remainQ == CNT_W'(1)) begin
                            stateD  = StIdle;
                            curCmdD = '0;
                        end
                    end
                end
                StDrain: begin
                    if (!i_stillIDCT) begin
                        stateD  = StIdle;
                        curCmdD = '0;
                    end
                end
                default: begin
                    stateD  = StIdle;
                    curCmdD = '0;
                end
            endcase
        end
    end

    mdec_tbl_loader u_tblLoader (
        .clk              (clk),
        .i_nrst           (i_nrst),
        .i_clear          (stateQ == StIdle),
        .i_wrEn           (tblWr),
        .i_isCos          (curCmdQ == OP_COS),
        .i_word           (bus.i_cmdWord),
        .o_quantWrt       (o_quantWrt),
        .o_quantValue     (o_quantValue),
        .o_quantAdr       (o_quantAdr),
        .o_quantTblSelect (o_quantTblSelect),
        .o_cosWrite       (o_cosWrite),
        .o_cosIndex       (o_cosIndex),
        .o_cosVal         (o_cosVal)
    );

    assign o_bitSetupDepth = depthQ;
    assign o_bitSigned     = signQ;
    assign o_busy          = (stateQ != StIdle);
    assign o_curCmd        = curCmdQ;
    assign o_remain        = remainQ;

endmodule

// File: tb/tb_mdec_cmd_sequencer.sv
// Scoreboard bench for mdec_cmd_sequencer: directed command streams push their
// expected core-port writes into queues; a monitor pops and compares on every strobe.
module tb_mdec_cmd_sequencer;
    import mdec_cmd_sequencer_pkg::*;

    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic             stillIDCT = 1'b0;
    logic             abort = 1'b0;
    logic [1:0]       depth;
    logic             sgn;
    logic             quantWrt;
    logic [27:0]      quantValue;
    logic [3:0]       quantAdr;
    logic             quantSel;
    logic             cosWrite;
    logic [4:0]       cosIndex;
    logic [25:0]      cosVal;
    logic             busy;
    logic [2:0]       curCmd;
    logic [CNT_W-1:0] remain;

    mdec_cmd_sequencer_if bus ();

    always #5 clk = ~clk;

    mdec_cmd_sequencer #(.CNT_W(CNT_W)) dut (
        .clk              (clk),
        .i_nrst           (nrst),
`ifdef MDEC_SEQ_ABORT_EN
        .i_abort          (abort),
`endif
        .bus              (bus),
        .i_stillIDCT      (stillIDCT),
        .o_bitSetupDepth  (depth),
        .o_bitSigned      (sgn),
        .o_quantWrt       (quantWrt),
        .o_quantValue     (quantValue),
        .o_quantAdr       (quantAdr),
        .o_quantTblSelect (quantSel),
        .o_cosWrite       (cosWrite),
        .o_cosIndex       (cosIndex),
        .o_cosVal         (cosVal),
        .o_busy           (busy),
        .o_curCmd         (curCmd),
        .o_remain         (remain)
    );

    typedef struct { logic [15:0] hw; logic [1:0] depth; logic sgn; } hwExp_t;
    typedef struct { logic [27:0] value; logic [3:0] adr; logic sel; } qExp_t;
    typedef struct { logic [4:0] idx; logic [25:0] val; } cExp_t;

    int          nVec = 0;
    int          nMis = 0;
    logic [31:0] fifo[$];
    hwExp_t      expHw[$];
    qExp_t       expQ[$];
    cExp_t       expC[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pushHw(input logic [15:0] hw, input logic [1:0] d, input logic s);
        hwExp_t e;
        e.hw = hw; e.depth = d; e.sgn = s;
        expHw.push_back(e);
    endtask

    task automatic pushQ(input logic [27:0] v, input logic [3:0] a, input logic s);
        qExp_t e;
        e.value = v; e.adr = a; e.sel = s;
        expQ.push_back(e);
    endtask

    task automatic pushC(input logic [4:0] i, input logic [25:0] v);
        cExp_t e;
        e.idx = i; e.val = v;
        expC.push_back(e);
    endtask

    task automatic waitBusy(input int maxCyc, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < maxCyc);
        check({name, "_busy"}, busy, 1);
    endtask

    task automatic waitDrained(input int maxCyc, input string name);
        int n = 0;
        while ((expHw.size() + expQ.size() + expC.size()) != 0 && n < maxCyc) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, expHw.size() + expQ.size() + expC.size(), 0);
    endtask

    task automatic waitIdle(input int maxCyc, input string name);
        int n = 0;
        while ((busy || fifo.size() != 0) && n < maxCyc) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, busy, 0);
    endtask

    // Command FIFO model: pop decided from the strobe seen mid-cycle.
    initial begin : fifoDrv
        logic popNow;
        bus.i_cmdValid = 1'b0;
        bus.i_cmdWord  = '0;
        forever begin
            @(negedge clk);
            popNow = bus.o_cmdPop;
            @(posedge clk);
            #1;
            if (popNow && fifo.size() > 0) void'(fifo.pop_front());
            bus.i_cmdValid = (fifo.size() > 0);
            bus.i_cmdWord  = (fifo.size() > 0) ? fifo[0] : 32'h0;
        end
    end

    initial begin : monitor
        hwExp_t eh;
        qExp_t  eq;
        cExp_t  ec;
        forever begin
            @(negedge clk);
            if (nrst) begin
                if (bus.o_dataWrite) begin
                    if (expHw.size() == 0) begin
                        check("unexpected_dataWrite", bus.o_dataWrite, 0);
                    end else begin
                        eh = expHw.pop_front();
                        check("halfword", bus.o_dataIn, eh.hw);
                        check("depth", depth, eh.depth);
                        check("signed", sgn, eh.sgn);
                        check("pop_during_write", bus.o_cmdPop, 0);
                    end
                end
                if (quantWrt) begin
                    if (expQ.size() == 0) begin
                        check("unexpected_quantWrt", quantWrt, 0);
                    end else begin
                        eq = expQ.pop_front();
                        check("quant_value", quantValue, eq.value);
                        check("quant_adr", quantAdr, eq.adr);
                        check("quant_sel", quantSel, eq.sel);
                    end
                end
                if (cosWrite) begin
                    if (expC.size() == 0) begin
                        check("unexpected_cosWrite", cosWrite, 0);
                    end else begin
                        ec = expC.pop_front();
                        check("cos_index", cosIndex, ec.idx);
                        check("cos_val", cosVal, ec.val);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [4:0]  kk;
        logic [27:0] qv;
        int          n;
        bus.i_allowLoad = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_curCmd", curCmd, 0);
        check("rst_remain", remain, 0);
        check("rst_depth", depth, 0);
        check("rst_signed", sgn, 0);
        check("rst_dataWrite", bus.o_dataWrite, 0);
        check("rst_dataIn", bus.o_dataIn, 0);
        check("rst_cmdPop", bus.o_cmdPop, 0);
        check("rst_quantWrt", quantWrt, 0);
        check("rst_cosWrite", cosWrite, 0);
        nrst = 1'b1;

        // 1: plain decode, depth 1 unsigned, drain held by the IDCT
        stillIDCT = 1'b1;
        fifo.push_back(32'h2800_0002);
        fifo.push_back(32'h0002_0001);
        fifo.push_back(32'h0004_0003);
        pushHw(16'h0001, 2'd1, 1'b0);
        pushHw(16'h0002, 2'd1, 1'b0);
        pushHw(16'h0003, 2'd1, 1'b0);
        pushHw(16'h0004, 2'd1, 1'b0);
        waitBusy(20, "t1");
        check("t1_remain", remain, 2);
        check("t1_curCmd", curCmd, 1);
        check("t1_depth", depth, 1);
        check("t1_signed", sgn, 0);
        waitDrained(50, "t1");
        repeat (3) begin
            @(negedge clk);
            check("t1_drain_busy", busy, 1);
        end
        check("t1_drain_curCmd", curCmd, 1);
        @(posedge clk); #1;
        stillIDCT = 1'b0;
        @(negedge clk);
        check("t1_drain_last", busy, 1);
        @(negedge clk);
        check("t1_idle_busy", busy, 0);
        check("t1_idle_curCmd", curCmd, 0);
        check("t1_idle_remain", remain, 0);
        check("t1_depth_held", depth, 1);

        // 2: backpressure for 5 cycles in DEC_HI
        fifo.push_back(32'h2800_0002);
        fifo.push_back(32'h0002_0001);
        fifo.push_back(32'h0004_0003);
        pushHw(16'h0001, 2'd1, 1'b0);
        pushHw(16'h0002, 2'd1, 1'b0);
        pushHw(16'h0003, 2'd1, 1'b0);
        pushHw(16'h0004, 2'd1, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.o_dataWrite && n < 20);
        check("t2_first_write", bus.o_dataWrite, 1);
        @(posedge clk); #1;
        bus.i_allowLoad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("t2_stall_write", bus.o_dataWrite, 0);
            check("t2_stall_pop", bus.o_cmdPop, 0);
            @(posedge clk); #1;
        end
        bus.i_allowLoad = 1'b1;
        waitDrained(30, "t2");
        waitIdle(10, "t2");

        // 3: quant, both tables
        qv = {7'h01, 7'h02, 7'h03, 7'h04};
        fifo.push_back(32'h4000_0001);
        for (int k = 0; k < 32; k++) begin
            fifo.push_back(32'h0102_0304);
            kk = k[4:0];
            pushQ(qv, kk[3:0], kk[4]);
        end
        waitDrained(100, "t3");
        waitIdle(10, "t3");
        check("t3_curCmd", curCmd, 0);

        // 4: cos table, must not wait for the IDCT
        stillIDCT = 1'b1;
        fifo.push_back(32'h6000_0000);
        for (int k = 0; k < 32; k++) begin
            fifo.push_back(32'h1FFF_0001);
            kk = k[4:0];
            pushC(kk, {13'h1FFF, 13'h0001});
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(cosWrite && cosIndex == 5'd31) && n < 100);
        check("t4_last_index", cosIndex, 31);
        @(negedge clk);
        check("t4_no_drain_busy", busy, 0);
        check("t4_curCmd", curCmd, 0);
        stillIDCT = 1'b0;

        // 5a: decode with length 0, depth 2 signed
        fifo.push_back(32'h3400_0000);
        waitBusy(20, "t5a");
        check("t5a_curCmd", curCmd, 1);
        check("t5a_remain", remain, 0);
        check("t5a_depth", depth, 2);
        check("t5a_signed", sgn, 1);
        @(negedge clk);
        check("t5a_idle", busy, 0);

        // 5b: opcodes 0 and 7 are consumed as no-ops
        fifo.push_back(32'h0000_1234);
        fifo.push_back(32'hE000_0005);
        repeat (4) begin
            @(negedge clk);
            check("t5b_busy", busy, 0);
        end
        check("t5b_popped", fifo.size(), 0);
        check("t5b_depth_kept", depth, 2);
        check("t5b_signed_kept", sgn, 1);

        // 5c: reset in the middle of a quant load
        fifo.push_back(32'h4000_0000);
        for (int k = 0; k < 5; k++) begin
            fifo.push_back(k);
            kk = k[4:0];
            pushQ(28'(k), kk[3:0], 1'b0);
        end
        waitDrained(30, "t5c");
        @(negedge clk);
        check("t5c_busy", busy, 1);
        check("t5c_curCmd", curCmd, 2);
        check("t5c_remain", remain, 11);
        #2;
        nrst = 1'b0;
        bus.i_cmdValid = 1'b0;
        fifo.delete();
        #1;
        check("t5c_rst_busy", busy, 0);
        check("t5c_rst_curCmd", curCmd, 0);
        check("t5c_rst_remain", remain, 0);
        check("t5c_rst_depth", depth, 0);
        check("t5c_rst_signed", sgn, 0);
        check("t5c_rst_quantWrt", quantWrt, 0);
        check("t5c_rst_quantValue", quantValue, 0);
        check("t5c_rst_cmdPop", bus.o_cmdPop, 0);
        @(negedge clk);
        nrst = 1'b1;

`ifdef MDEC_SEQ_ABORT_EN
        // 6: abort while FETCH waits for a parameter word
        fifo.push_back(32'h2800_0003);
        waitBusy(20, "t6");
        repeat (2) @(negedge clk);
        stillIDCT = 1'b1;
        @(posedge clk); #1;
        abort = 1'b1;
        fifo.push_back(32'h0000_0000);
        bus.i_cmdValid = 1'b1;
        bus.i_cmdWord  = 32'h0000_0000;
        @(negedge clk);
        check("t6_abort_pop", bus.o_cmdPop, 0);
        check("t6_abort_write", bus.o_dataWrite, 0);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("t6_drain_busy", busy, 1);
        check("t6_drain_remain", remain, 0);
        check("t6_drain_curCmd", curCmd, 1);
        repeat (3) begin
            @(negedge clk);
            check("t6_drain_pop", bus.o_cmdPop, 0);
        end
        fifo.delete();
        bus.i_cmdValid = 1'b0;
        @(posedge clk); #1;
        stillIDCT = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_idle_busy", busy, 0);
        check("t6_idle_remain", remain, 0);
`endif

        repeat (2) @(negedge clk);
        check("end_hw_left", expHw.size(), 0);
        check("end_quant_left", expQ.size(), 0);
        check("end_cos_left", expC.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
